// File: rtl/sprite_attr_reader_pkg.sv
// Shared definitions for the sprite attribute reader.
//   - attribute record layout (stride, word offsets, enable bit)
//   - default attribute base address
//   - number of words fetched per sprite. The control word is only fetched
//     when SPRITE_ATTR_ENABLE_EN is defined.
//   - FSM state encoding
// Macro: SPRITE_ATTR_ENABLE_EN
package sprite_attr_reader_pkg;

   localparam int REC_STRIDE  = 4;
   localparam int WORD_X      = 0;
   localparam int WORD_Y      = 1;
   localparam int WORD_F      = 2;
   localparam int WORD_CTRL   = 3;
   localparam int CTRL_EN_BIT = 0;

   localparam int unsigned DEFAULT_BASE_ADDR = 32'h1000;

`ifdef SPRITE_ATTR_ENABLE_EN
   localparam int WORDS_PER_SPRITE = WORD_CTRL + 1;
`else
   localparam int WORDS_PER_SPRITE = WORD_CTRL;
`endif

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_READ   = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_COMMIT = 2'd3;

   function automatic int word_offset(input int sprite, input int word);
      return REC_STRIDE * sprite + word;
   endfunction

endpackage

// File: rtl/sprite_attr_addr_gen.sv
// Sprite/word counter and RAM address generator.
// Ports:
//   clk, reset_n  clock and async active-low reset
//   clear         restart the walk at sprite 0, word 0
//   active        the read port is requested; addr is 0 otherwise
//   advance       a read was issued this cycle, so step to the next word
//   sprite_idx    current sprite index
//   word_idx      current word index within the record
//   last_word     current word is the final word of the final sprite
//   addr          BASE_ADDR + stride*sprite + word, or 0 when not active
module sprite_attr_addr_gen
   import sprite_attr_reader_pkg::*;
#(
   parameter int          ADDR_WIDTH  = 16,
   parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int          NUM_SPRITES = 4,
   parameter int          SPR_W       = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  active,
   input  logic                  advance,
   output logic [SPR_W-1:0]      sprite_idx,
   output logic [1:0]            word_idx,
   output logic                  last_word,
   output logic [ADDR_WIDTH-1:0] addr
);

   logic last_in_rec;
   logic last_sprite;

   assign last_in_rec = (word_idx == 2'(WORDS_PER_SPRITE - 1));
   assign last_sprite = (sprite_idx == SPR_W'(NUM_SPRITES - 1));
   assign last_word   = last_in_rec && last_sprite;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sprite_idx <= '0;
         word_idx   <= '0;
      end else if (clear) begin
         sprite_idx <= '0;
         word_idx   <= '0;
      end else if (advance) begin
         if (last_in_rec) begin
            word_idx   <= '0;
            sprite_idx <= last_sprite ? '0 : sprite_idx + SPR_W'(1);
         end else begin
            word_idx   <= word_idx + 2'(1);
         end
      end
   end

   always_comb begin
      addr = '0;
      if (active)
         addr = ADDR_WIDTH'(BASE_ADDR + word_offset(int'(sprite_idx), int'(word_idx)));
   end

endmodule

// File: rtl/sprite_attr_reader.sv
// Sprite attribute reader. On each frame_start it walks the sprite attribute
// records in RAM, stages every word, and publishes all sprites in one commit.
// Ports:
//   clk, reset_n            clock and async active-low reset
//   frame_start             vertical-blank pulse that starts a fetch
//   gnt                     the arbiter granted the read port this cycle
//   data_in                 RAM read data, one cycle after the issuing cycle
//   req, addr               RAM read request and address (addr 0 when idle)
//   attr_x/attr_y/attr_f    committed x, y and frame, DATA_WIDTH per sprite
//   attr_en                 committed per-sprite enable
//   busy, done, overrun     fetch active, commit pulse, sticky missed frame
// Macro: SPRITE_ATTR_ENABLE_EN fetches the control word and drives attr_en
// from its enable bit. Without it, attr_en goes all-ones at the first commit.
//
// state  | meaning
// IDLE   | waiting for frame_start
// READ   | requesting words, stalls while gnt is low
// DRAIN  | no request, captures the last returned word
// COMMIT | staging copied to attr_*, done pulses
module sprite_attr_reader
   import sprite_attr_reader_pkg::*;
#(
   parameter int          DATA_WIDTH  = 16,
   parameter int          ADDR_WIDTH  = 16,
   parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int          NUM_SPRITES = 4
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              frame_start,
   input  logic                              gnt,
   input  logic [DATA_WIDTH-1:0]             data_in,
   output logic                              req,
   output logic [ADDR_WIDTH-1:0]             addr,
   output logic [NUM_SPRITES*DATA_WIDTH-1:0] attr_x,
   output logic [NUM_SPRITES*DATA_WIDTH-1:0] attr_y,
   output logic [NUM_SPRITES*DATA_WIDTH-1:0] attr_f,
   output logic [NUM_SPRITES-1:0]            attr_en,
   output logic                              busy,
   output logic                              done,
   output logic                              overrun
);

   localparam int SPR_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             start;
   logic             issue;
   logic             last_word;
   logic [SPR_W-1:0] sprite_idx;
   logic [1:0]       word_idx;

   // The issued word's location travels one cycle alongside the RAM latency.
   logic             cap_vld;
   logic [SPR_W-1:0] cap_sprite;
   logic [1:0]       cap_word;

   logic [NUM_SPRITES*DATA_WIDTH-1:0] stage_x;
   logic [NUM_SPRITES*DATA_WIDTH-1:0] stage_y;
   logic [NUM_SPRITES*DATA_WIDTH-1:0] stage_f;
`ifdef SPRITE_ATTR_ENABLE_EN
   logic [NUM_SPRITES-1:0]            stage_en;
`endif

   assign start = (state == ST_IDLE) && frame_start;
   assign req   = (state == ST_READ);
   assign issue = req && gnt;
   assign busy  = (state != ST_IDLE);
   assign done  = (state == ST_COMMIT);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (frame_start) state_nxt = ST_READ;
         ST_READ:   if (issue && last_word) state_nxt = ST_DRAIN;
         ST_DRAIN:  state_nxt = ST_COMMIT;
         ST_COMMIT: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         overrun <= 1'b0;
      end else begin
         state <= state_nxt;
         if (frame_start && (state != ST_IDLE))
            overrun <= 1'b1;
      end
   end

   sprite_attr_addr_gen #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .BASE_ADDR   (BASE_ADDR),
      .NUM_SPRITES (NUM_SPRITES),
      .SPR_W       (SPR_W)
   ) u_addr_gen (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (start),
      .active     (req),
      .advance    (issue),
      .sprite_idx (sprite_idx),
      .word_idx   (word_idx),
      .last_word  (last_word),
      .addr       (addr)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cap_vld    <= 1'b0;
         cap_sprite <= '0;
         cap_word   <= '0;
      end else begin
         cap_vld    <= issue;
         cap_sprite <= sprite_idx;
         cap_word   <= word_idx;
      end
   end

   // Capture depends only on the issue one cycle earlier, not on this cycle's gnt.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage_x  <= '0;
         stage_y  <= '0;
         stage_f  <= '0;
`ifdef SPRITE_ATTR_ENABLE_EN
         stage_en <= '0;
`endif
      end else if (cap_vld) begin
         case (cap_word)
            2'(WORD_X): stage_x[int'(cap_sprite)*DATA_WIDTH +: DATA_WIDTH] <= data_in;
            2'(WORD_Y): stage_y[int'(cap_sprite)*DATA_WIDTH +: DATA_WIDTH] <= data_in;
            2'(WORD_F): stage_f[int'(cap_sprite)*DATA_WIDTH +: DATA_WIDTH] <= data_in;
`ifdef SPRITE_ATTR_ENABLE_EN
            2'(WORD_CTRL): stage_en[cap_sprite] <= data_in[CTRL_EN_BIT];
`endif
            default: ;
         endcase
      end
   end

   // All sprites are published on one edge, so no frame ever sees a mix of
   // old and new attributes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         attr_x  <= '0;
         attr_y  <= '0;
         attr_f  <= '0;
         attr_en <= '0;
      end else if (state == ST_COMMIT) begin
         attr_x  <= stage_x;
         attr_y  <= stage_y;
         attr_f  <= stage_f;
`ifdef SPRITE_ATTR_ENABLE_EN
         attr_en <= stage_en;
`else
         attr_en <= '1;
`endif
      end
   end

endmodule

// File: tb/tb_sprite_attr_reader.sv
// Self-checking bench for sprite_attr_reader (default parameters).
// A behavioural model tracks the fetch as an index over the issued words and
// keeps the RAM contents as an array. It predicts every output on every cycle,
// and fixed expectations pin the model at the key latencies and values.
// Macro: SPRITE_ATTR_ENABLE_EN selects a 4-word record; otherwise 3 words.
module tb_sprite_attr_reader;

   localparam int DW   = 16;
   localparam int AW   = 16;
   localparam int N    = 4;
   localparam int BASE = 'h1000;
`ifdef SPRITE_ATTR_ENABLE_EN
   localparam int W        = 4;
   localparam int DONE_CYC = 18;
`else
   localparam int W        = 3;
   localparam int DONE_CYC = 14;
`endif

   logic            clk;
   logic            reset_n;
   logic            frame_start;
   logic            gnt;
   logic [DW-1:0]   data_in;
   logic            req;
   logic [AW-1:0]   addr;
   logic [N*DW-1:0] attr_x;
   logic [N*DW-1:0] attr_y;
   logic [N*DW-1:0] attr_f;
   logic [N-1:0]    attr_en;
   logic            busy;
   logic            done;
   logic            overrun;

   sprite_attr_reader #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .BASE_ADDR   (BASE),
      .NUM_SPRITES (N)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .frame_start (frame_start),
      .gnt         (gnt),
      .data_in     (data_in),
      .req         (req),
      .addr        (addr),
      .attr_x      (attr_x),
      .attr_y      (attr_y),
      .attr_f      (attr_f),
      .attr_en     (attr_en),
      .busy        (busy),
      .done        (done),
      .overrun     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   typedef enum int {P_IDLE, P_FETCH, P_DRAIN, P_COMMIT} phase_t;
   phase_t          m_phase;
   int              m_idx;
   logic [DW-1:0]   m_ram [16];
   logic [DW-1:0]   m_sx [N];
   logic [DW-1:0]   m_sy [N];
   logic [DW-1:0]   m_sf [N];
   logic            m_sc [N];
   logic [N*DW-1:0] e_x, e_y, e_f;
   logic [N-1:0]    e_en;
   logic            e_ovr;
   logic [DW-1:0]   nxt_data;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic model_reset();
      m_phase  = P_IDLE;
      m_idx    = 0;
      e_x      = '0;
      e_y      = '0;
      e_f      = '0;
      e_en     = '0;
      e_ovr    = 1'b0;
      nxt_data = '0;
      for (int s = 0; s < N; s++) begin
         m_sx[s] = '0; m_sy[s] = '0; m_sf[s] = '0; m_sc[s] = 1'b0;
      end
   endtask

   // One clock cycle: drive inputs and check outputs at the falling edge,
   // then advance the model across the coming rising edge.
   task automatic cycle(input logic fs, input logic g, output logic o_done, output logic [AW-1:0] o_addr);
      logic          er;
      logic [AW-1:0] ea;
      int            s, w, off;
      @(negedge clk);
      frame_start = fs;
      gnt         = g;
      data_in     = nxt_data;
      s   = m_idx / W;
      w   = m_idx % W;
      off = 4 * s + w;
      er  = (m_phase == P_FETCH);
      ea  = er ? AW'(BASE + off) : '0;
      chk("req", req, er);
      chk("addr", addr, ea);
      chk("busy", busy, m_phase != P_IDLE);
      chk("done", done, m_phase == P_COMMIT);
      chk("overrun", overrun, e_ovr);
      chk("attr_x", attr_x, e_x);
      chk("attr_y", attr_y, e_y);
      chk("attr_f", attr_f, e_f);
      chk("attr_en", attr_en, e_en);
`ifndef SPRITE_ATTR_ENABLE_EN
      if (req) chk("ctrl_word_never_read", addr[1:0] == 2'b11, 1'b0);
`endif
      o_done = done;
      o_addr = addr;
      nxt_data = DW'($urandom);
      if (fs && m_phase != P_IDLE) e_ovr = 1'b1;
      case (m_phase)
         P_IDLE: if (fs) begin m_phase = P_FETCH; m_idx = 0; end
         P_FETCH: if (g) begin
            nxt_data = m_ram[off];
            if (w == 0)      m_sx[s] = m_ram[off];
            else if (w == 1) m_sy[s] = m_ram[off];
            else if (w == 2) m_sf[s] = m_ram[off];
            else             m_sc[s] = m_ram[off][0];
            m_idx++;
            if (m_idx == N * W) m_phase = P_DRAIN;
         end
         P_DRAIN: m_phase = P_COMMIT;
         P_COMMIT: begin
            for (int k = 0; k < N; k++) begin
               e_x[k*DW +: DW] = m_sx[k];
               e_y[k*DW +: DW] = m_sy[k];
               e_f[k*DW +: DW] = m_sf[k];
`ifdef SPRITE_ATTR_ENABLE_EN
               e_en[k] = m_sc[k];
`else
               e_en[k] = 1'b1;
`endif
            end
            m_phase = P_IDLE;
         end
         default: m_phase = P_IDLE;
      endcase
   endtask

   // Asserts reset part-way through a cycle and checks the outputs clear without waiting for a clock edge.
   task automatic async_reset();
      @(negedge clk);
      #2;
      reset_n     = 1'b0;
      frame_start = 1'b0;
      gnt         = 1'b0;
      #1;
      chk("rst_req", req, 1'b0);
      chk("rst_addr", addr, 16'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_overrun", overrun, 1'b0);
      chk("rst_attr_x", attr_x, 64'h0);
      chk("rst_attr_y", attr_y, 64'h0);
      chk("rst_attr_f", attr_f, 64'h0);
      chk("rst_attr_en", attr_en, 4'h0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic          od;
      logic [AW-1:0] oa;
      int            done_at;
      int            n_done;

      reset_n     = 1'b0;
      frame_start = 1'b0;
      gnt         = 1'b0;
      data_in     = '0;
      for (int i = 0; i < 16; i++) m_ram[i] = DW'($urandom);
      m_ram[0] = 16'd100; m_ram[1] = 16'd200; m_ram[2] = 16'd2; m_ram[3] = 16'd1;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;

      // Basic fetch with gnt held high.
      done_at = -1;
      for (int c = 0; c <= DONE_CYC + 1; c++) begin
         cycle(c == 0, 1'b1, od, oa);
         if (od && done_at < 0) done_at = c;
         if (c == 1) chk("t1_first_addr", oa, 16'h1000);
         if (c == DONE_CYC + 1) begin
            chk("t1_attr_x0", attr_x[15:0], 16'd100);
            chk("t1_attr_y0", attr_y[15:0], 16'd200);
            chk("t1_attr_f0", attr_f[15:0], 16'd2);
            chk("t1_attr_en0", attr_en[0], 1'b1);
`ifndef SPRITE_ATTR_ENABLE_EN
            chk("t1_attr_en_all", attr_en, 4'b1111);
`endif
         end
      end
      chk("t1_done_cycle", done_at, DONE_CYC);

      // gnt withheld for cycles 3..5: address holds, done slips by three cycles.
      done_at = -1;
      for (int c = 0; c <= DONE_CYC + 5; c++) begin
         cycle(c == 0, !(c >= 3 && c <= 5), od, oa);
         if (od && done_at < 0) done_at = c;
         if (c >= 3 && c <= 6) chk("t2_stall_addr", oa, 16'h1002);
      end
      chk("t2_done_cycle", done_at, DONE_CYC + 3);
      chk("t2_attr_x0", attr_x[15:0], 16'd100);

      // RAM x of sprite 0 changes after it was read: committed value is the old one.
      for (int c = 0; c <= DONE_CYC + 1; c++) begin
         cycle(c == 0, 1'b1, od, oa);
         if (c == 5) m_ram[0] = 16'd104;
         if (c == 10) chk("t3_x_held_busy", attr_x[15:0], 16'd100);
      end
      chk("t3_x_old_committed", attr_x[15:0], 16'd100);
      for (int c = 0; c <= DONE_CYC + 1; c++) cycle(c == 0, 1'b1, od, oa);
      chk("t3_x_new_frame", attr_x[15:0], 16'd104);
      chk("t3_no_overrun_yet", overrun, 1'b0);

      // frame_start mid-fetch and in the COMMIT cycle.
      n_done = 0;
      for (int c = 0; c <= DONE_CYC + 6; c++) begin
         cycle(c == 0 || c == 5 || c == DONE_CYC, 1'b1, od, oa);
         if (od) n_done++;
      end
      chk("t4_single_done", n_done, 1);
      chk("t4_overrun_set", overrun, 1'b1);
      chk("t4_idle_after", busy, 1'b0);

      // Reset during cycle 7 of a fetch.
      n_done = 0;
      for (int c = 0; c <= 6; c++) begin
         cycle(c == 0, 1'b1, od, oa);
         if (od) n_done++;
      end
      async_reset();
      chk("t5_no_done", n_done, 0);
      done_at = -1;
      for (int c = 0; c <= DONE_CYC + 1; c++) begin
         cycle(c == 0, 1'b1, od, oa);
         if (od && done_at < 0) done_at = c;
         if (c == 1) chk("t5_restart_addr", oa, 16'h1000);
      end
      chk("t5_done_cycle", done_at, DONE_CYC);

      // Randomised traffic: random grants, frame pulses, RAM writes, occasional reset.
      for (int c = 0; c < 1500; c++) begin
         cycle($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, od, oa);
         if ($urandom_range(0, 7) == 0) m_ram[$urandom_range(0, 15)] = DW'($urandom);
         if ($urandom_range(0, 499) == 0) async_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sprite_attr_reader.md
SPRITE_ATTR_READER -- requirements
Module: sprite_attr_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, attribute word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, attribute RAM address width.
REQ-003 SHALL have parameter BASE_ADDR, default 'h1000, address of sprite 0 word 0.
REQ-004 SHALL have parameter NUM_SPRITES, default 4, number of sprite records read per frame.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port frame_start  input  1  one-cycle pulse at vertical-blank start.
REQ-008 SHALL have port gnt  input  1  RAM read port granted by arbiter this cycle.
REQ-009 SHALL have port data_in  input  DATA_WIDTH  RAM read data, valid one cycle after the issuing cycle.
REQ-010 SHALL have port req  output  1  RAM access request.
REQ-011 SHALL have port addr  output  ADDR_WIDTH  RAM read address.
REQ-012 SHALL have ports attr_x, attr_y, attr_f  output  NUM_SPRITES*DATA_WIDTH each  committed per-sprite x, y, animation frame; sprite n at bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have port attr_en  output  NUM_SPRITES  committed per-sprite enable.
REQ-014 SHALL have ports busy, done, overrun  output  1 each  fetch in progress; one-cycle commit pulse; sticky missed-frame flag.

Function
REQ-015 Record layout: stride 4 words; word 0 = x, word 1 = y, word 2 = frame index, word 3 = control (bit0 = enable); addr = BASE_ADDR + 4*sprite + word.
REQ-016 Block SHALL never write the RAM; it has no write-enable output.
REQ-017 FSM states: IDLE, READ, DRAIN, COMMIT.
REQ-018 IDLE: req=0, busy=0; frame_start=1 SHALL move to READ with word/sprite counters cleared.
REQ-019 READ: req=1, busy=1, addr = current word address; a read is issued in each cycle with gnt=1, after which the counter advances; gnt=0 holds addr and counter (stall).
REQ-020 Data captured into staging registers on the edge after each issuing cycle, independent of gnt in that capture cycle.
REQ-021 After issuing the last word of sprite NUM_SPRITES-1, SHALL go to DRAIN (req=0, captures final word), then COMMIT.
REQ-022 COMMIT: done=1 for exactly one cycle; all staging registers SHALL copy to attr_* on the COMMIT edge together (no torn sprite visible); next state IDLE.
REQ-023 Latency with gnt held 1, W words per sprite: frame_start at cycle 0 -> reads issued cycles 1..NUM_SPRITES*W, DRAIN next, done in the following cycle, new attr_* visible the cycle after done.
REQ-024 attr_* SHALL hold their committed values at all other times.
REQ-025 frame_start outside IDLE (including the COMMIT cycle) SHALL be ignored and set overrun; overrun clears only on reset.
REQ-026 addr SHALL be 0 whenever req=0.

Reset
REQ-027 reset_n=0 SHALL asynchronously force IDLE, counters 0, req=0, addr=0, busy=0, done=0, overrun=0, attr_x/attr_y/attr_f all 0, attr_en all 0, staging registers 0.
REQ-028 Reset mid-fetch SHALL abandon the fetch with no partial commit; the next frame_start after release starts from sprite 0 word 0.

Configuration
REQ-029 Macro SPRITE_ATTR_ENABLE_EN: when defined, W=4 and attr_en[n] = bit0 of word 3 of sprite n.
REQ-030 Without SPRITE_ATTR_ENABLE_EN: W=3, word 3 never read, attr_en forced all-ones from first commit (0 in reset).

Structure
REQ-031 Shared package SHALL hold: record stride (4), word offsets (X=0, Y=1, F=2, CTRL=3), CTRL enable bit index, default BASE_ADDR, FSM state encoding.
REQ-032 Address generator (sprite/word counter, stall, addr compute) SHALL be sub-module sprite_attr_addr_gen; remainder in top.

Verification
REQ-033 Defaults, macro on, gnt=1, RAM sprite 0 = {x=100, y=200, f=2, ctrl=1}: frame_start at cycle 0 -> done at cycle 18, attr_x[15:0]=100, attr_y[15:0]=200, attr_f[15:0]=2, attr_en[0]=1 from cycle 19.
REQ-034 gnt low for cycles 3-5 of a fetch: addr holds 'h1002 through stall, done delayed exactly 3 cycles, captured values correct.
REQ-035 RAM x of sprite 0 changed 100->104 while busy after its word was read: attr_x keeps 100 until next frame, old values held until done.
REQ-036 frame_start pulsed in cycle 5 and in COMMIT cycle: both ignored, overrun=1 and stays 1 until reset_n=0.
REQ-037 reset_n low at cycle 7 of a fetch: all outputs 0 immediately, no done; fresh fetch after release reads addr 'h1000 first.
REQ-038 Macro off, same RAM: done at cycle 14, addresses 'h1003/'h1007/'h100B/'h100F never driven, attr_en=4'b1111.
